// File: rtl/gshare_history_unit_pkg.sv
// Shared types and helpers for the gshare history unit.
// Pure functions only; no state, no latency.
// No flow control of its own.
package gshare_pkg;

  // One checkpoint entry is the PHT index plus the predicted direction.
  function automatic int ckpt_width(input int idx_w);
    return idx_w + 1;
  endfunction

  // Fold the history down to the index width. Bit i of the history lands
  // on index bit (i mod idx_w), which XORs consecutive idx_w-bit chunks
  // together with the top chunk implicitly zero-padded. A history no wider
  // than the index comes out zero-extended. Supports ghr_w <= 64, idx_w <= 32.
  function automatic logic [31:0] fold_ghr(input logic [63:0] ghr,
                                           input int ghr_w,
                                           input int idx_w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < ghr_w) r = r ^ (32'(ghr[6'(i)]) << (i % idx_w));
    end
    return r;
  endfunction

endpackage

// File: rtl/gshare_history_unit_if.sv
// Bundle of fetch, resolve and status signals of the gshare history unit.
// Wires only; no latency.
// Backpressure to fetch is carried by ckpt_full.
interface gshare_history_unit_if #(
  parameter int GHR_W = 8,
  parameter int IDX_W = 4,
  parameter int DEPTH = 4
);
  logic                       fetch_valid;
  logic                       fetch_is_branch;
  logic [31:0]                fetch_pc;
  logic                       pred_taken;
  logic [IDX_W-1:0]           index;
  logic                       ckpt_full;
  logic                       resolve_valid;
  logic                       resolve_taken;
  logic [IDX_W-1:0]           upd_index;
  logic                       mispredict;
  logic                       flush;
  logic [GHR_W-1:0]           spec_ghr;
  logic [GHR_W-1:0]           arch_ghr;
  logic [$clog2(DEPTH):0]     inflight;
  logic                       err_underflow;

  // Pipeline side: fetch, PHT and execute drive the requests.
  modport master (
    output fetch_valid, fetch_is_branch, fetch_pc, pred_taken,
    output resolve_valid, resolve_taken, flush,
    input  index, ckpt_full, upd_index, mispredict,
    input  spec_ghr, arch_ghr, inflight, err_underflow
  );

  // History unit side.
  modport slave (
    input  fetch_valid, fetch_is_branch, fetch_pc, pred_taken,
    input  resolve_valid, resolve_taken, flush,
    output index, ckpt_full, upd_index, mispredict,
    output spec_ghr, arch_ghr, inflight, err_underflow
  );
endinterface

// File: rtl/gshare_history_unit_ckpt_fifo.sv
// Synchronous checkpoint FIFO with clear, full/empty flags and occupancy.
// Write visible at the head one cycle after push; rdata is combinational.
// Caller must not push when full nor pop when empty; clear wins over both.
module ckpt_fifo #(
  parameter int W     = 5,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  input  logic                   clear,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Storage needs no reset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/gshare_history_unit.sv
// Gshare speculative/architectural history with per-branch checkpoints.
// index and mispredict are combinational; all state updates on the next edge.
// ckpt_full stalls fetch of new branches; resolve on empty only sets a flag.
module gshare_history_unit
  import gshare_pkg::*;
#(
  parameter int GHR_W  = 8,
  parameter int IDX_W  = 4,
  parameter int PC_LSB = 2,
  parameter int DEPTH  = 4
) (
  input logic                clk,
  input logic                rst_n,
  gshare_history_unit_if.slave hu
);
  localparam int CKW = ckpt_width(IDX_W);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             taken;
  } ckpt_t;

  logic [GHR_W-1:0]       spec_q;
  logic [GHR_W-1:0]       arch_q;
  logic [GHR_W-1:0]       arch_next;
  logic                   err_q;
  logic [63:0]            ghr_ext;
  logic [IDX_W-1:0]       idx_fold;
  logic [IDX_W-1:0]       index;
  ckpt_t                  wr_ent;
  ckpt_t                  head;
  logic [CKW-1:0]         head_raw;
  logic                   full;
  logic                   empty;
  logic [$clog2(DEPTH):0] count;
  logic                   push;
  logic                   pop;
  logic                   mispredict;
  logic                   clear;

  function automatic logic [GHR_W-1:0] shift_in(input logic [GHR_W-1:0] g,
                                                 input logic b);
    return GHR_W'({g, b});
  endfunction

  // Widen the speculative history so the fold helper sees a fixed width.
  always_comb begin
    ghr_ext              = '0;
    ghr_ext[GHR_W-1:0]   = spec_q;
  end

  assign idx_fold   = IDX_W'(fold_ghr(ghr_ext, GHR_W, IDX_W));
  assign index      = hu.fetch_pc[PC_LSB +: IDX_W] ^ idx_fold;
  assign head       = ckpt_t'(head_raw);

  assign pop        = hu.resolve_valid & ~empty;
  assign mispredict = pop & (hu.resolve_taken != head.taken);
  assign push       = hu.fetch_valid & hu.fetch_is_branch & ~full
                      & ~mispredict & ~hu.flush;
  assign clear      = mispredict | hu.flush;
  assign arch_next  = pop ? shift_in(arch_q, hu.resolve_taken) : arch_q;

  assign wr_ent.idx   = index;
  assign wr_ent.taken = hu.pred_taken;

  ckpt_fifo #(.W(CKW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wr_ent),
    .pop   (pop),
    .clear (clear),
    .rdata (head_raw),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // History registers: a clear rewinds speculation to the post-pop commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spec_q <= '0;
      arch_q <= '0;
    end else begin
      arch_q <= arch_next;
      if (clear)     spec_q <= arch_next;
      else if (push) spec_q <= shift_in(spec_q, hu.pred_taken);
    end
  end

  // Sticky underflow flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       err_q <= 1'b0;
    else if (hu.resolve_valid && empty) err_q <= 1'b1;
  end

  assign hu.index         = index;
  assign hu.ckpt_full     = full;
  assign hu.upd_index     = head.idx;
  assign hu.mispredict    = mispredict;
  assign hu.spec_ghr      = spec_q;
  assign hu.arch_ghr      = arch_q;
  assign hu.inflight      = count;
  assign hu.err_underflow = err_q;
endmodule

// File: tb/tb_gshare_history_unit.sv
// Randomized and directed bench for the gshare history unit against a
// queue-based reference model.
module tb_gshare_history_unit;
  localparam int G = 8;
  localparam int I = 4;
  localparam int D = 4;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  typedef struct {
    int idx;
    bit taken;
  } ent_t;

  ent_t q[$];
  int   spec_m;
  int   arch_m;
  bit   err_m;

  gshare_history_unit_if #(.GHR_W(G), .IDX_W(I), .DEPTH(D)) hu ();

  gshare_history_unit #(.GHR_W(G), .IDX_W(I), .PC_LSB(2), .DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hu    (hu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference index: XOR all 4-bit chunks of the history, then XOR with PC[5:2].
  function automatic int model_index(input logic [31:0] pc, input int spec);
    int h;
    h = 0;
    for (int c = 0; c * I < G; c++) h = h ^ ((spec >> (c * I)) & 'hF);
    return ((pc >> 2) & 'hF) ^ h;
  endfunction

  task automatic set_in(input bit fv, input bit fb, input logic [31:0] pc, input bit pt,
                        input bit rv, input bit rt, input bit fl);
    hu.fetch_valid     = fv;
    hu.fetch_is_branch = fb;
    hu.fetch_pc        = pc;
    hu.pred_taken      = pt;
    hu.resolve_valid   = rv;
    hu.resolve_taken   = rt;
    hu.flush           = fl;
  endtask

  // Apply one cycle of inputs, check all outputs before the edge, advance model.
  task automatic cycle(input bit fv, input bit fb, input logic [31:0] pc, input bit pt,
                       input bit rv, input bit rt, input bit fl);
    int  exp_idx;
    bit  empty_m;
    bit  full_m;
    bit  pop_m;
    bit  mis_m;
    bit  push_m;
    int  arch_new;
    ent_t e;
    set_in(fv, fb, pc, pt, rv, rt, fl);
    #3;
    exp_idx = model_index(pc, spec_m);
    empty_m = (q.size() == 0);
    full_m  = (q.size() == D);
    pop_m   = rv && !empty_m;
    mis_m   = pop_m && (rt != q[0].taken);
    push_m  = fv && fb && !full_m && !mis_m && !fl;
    chk("index", 32'(hu.index), exp_idx);
    chk("mispredict", 32'(hu.mispredict), 32'(mis_m));
    chk("ckpt_full", 32'(hu.ckpt_full), 32'(full_m));
    chk("spec_ghr", 32'(hu.spec_ghr), spec_m);
    chk("arch_ghr", 32'(hu.arch_ghr), arch_m);
    chk("inflight", 32'(hu.inflight), q.size());
    chk("err_underflow", 32'(hu.err_underflow), 32'(err_m));
    if (!empty_m) chk("upd_index", 32'(hu.upd_index), q[0].idx);
    @(posedge clk);
    if (rv && empty_m) err_m = 1'b1;
    arch_new = pop_m ? (((arch_m << 1) | int'(rt)) & 'hFF) : arch_m;
    if (mis_m || fl) begin
      q.delete();
      spec_m = arch_new;
    end else begin
      if (pop_m) void'(q.pop_front());
      if (push_m) begin
        e.idx   = exp_idx;
        e.taken = pt;
        q.push_back(e);
        spec_m = ((spec_m << 1) | int'(pt)) & 'hFF;
      end
    end
    arch_m = arch_new;
    #1;
  endtask

  // Asynchronous reset asserted away from the clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_spec", 32'(hu.spec_ghr), 0);
    chk("rst_arch", 32'(hu.arch_ghr), 0);
    chk("rst_inflight", 32'(hu.inflight), 0);
    chk("rst_err", 32'(hu.err_underflow), 0);
    chk("rst_full", 32'(hu.ckpt_full), 0);
    set_in(0, 0, 32'h0, 0, 0, 0, 0);
    #1;
    chk("rst_index", 32'(hu.index), 0);
    chk("rst_mispredict", 32'(hu.mispredict), 0);
    q.delete();
    spec_m = 0;
    arch_m = 0;
    err_m  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Push T,T,N,T at PCs 0x00..0x0C.
  task automatic fill4();
    cycle(1, 1, 32'h00, 1, 0, 0, 0);
    cycle(1, 1, 32'h04, 1, 0, 0, 0);
    cycle(1, 1, 32'h08, 0, 0, 0, 0);
    cycle(1, 1, 32'h0C, 1, 0, 0, 0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b1;
    set_in(0, 0, 32'h0, 0, 0, 0, 0);
    #2;
    do_reset();

    // Index at PC 0x10 with empty history, then one taken push.
    cycle(0, 0, 32'h0, 0, 0, 0, 0);
    set_in(1, 1, 32'h10, 1, 0, 0, 0);
    #1;
    chk("idx_pc10", 32'(hu.index), 4);
    cycle(1, 1, 32'h10, 1, 0, 0, 0);
    chk("push1_spec", 32'(hu.spec_ghr), 'h01);
    chk("push1_inflight", 32'(hu.inflight), 1);
    chk("push1_arch", 32'(hu.arch_ghr), 0);

    // Fill to full; a fifth push is ignored.
    do_reset();
    fill4();
    chk("fill_spec", 32'(hu.spec_ghr), 'h0D);
    chk("fill_full", 32'(hu.ckpt_full), 1);
    set_in(1, 1, 32'h0, 1, 0, 0, 0);
    #1;
    chk("idx_pc0_0d", 32'(hu.index), 'hD);
    cycle(1, 1, 32'h0, 1, 0, 0, 0);
    chk("blocked_spec", 32'(hu.spec_ghr), 'h0D);
    chk("blocked_inflight", 32'(hu.inflight), 4);

    // Correct resolve of the oldest branch.
    set_in(0, 0, 32'h0, 0, 1, 1, 0);
    #1;
    chk("res_mis", 32'(hu.mispredict), 0);
    chk("res_upd_index", 32'(hu.upd_index), 0);
    cycle(0, 0, 32'h0, 0, 1, 1, 0);
    chk("res_arch", 32'(hu.arch_ghr), 'h01);
    chk("res_inflight", 32'(hu.inflight), 3);

    // Mispredict from the full state with a simultaneous push.
    do_reset();
    fill4();
    set_in(1, 1, 32'h30, 1, 1, 0, 0);
    #1;
    chk("mis_flag", 32'(hu.mispredict), 1);
    cycle(1, 1, 32'h30, 1, 1, 0, 0);
    chk("mis_arch", 32'(hu.arch_ghr), 0);
    chk("mis_spec", 32'(hu.spec_ghr), 0);
    chk("mis_inflight", 32'(hu.inflight), 0);

    // Mispredict with room in the FIFO: the push must still be dropped.
    cycle(1, 1, 32'h00, 0, 0, 0, 0);
    cycle(1, 1, 32'h04, 1, 1, 1, 0);
    chk("mis2_inflight", 32'(hu.inflight), 0);
    chk("mis2_spec", 32'(hu.spec_ghr), 'h01);

    // Full FIFO: push + correct pop -> push blocked; then push + pop at 3.
    do_reset();
    fill4();
    cycle(1, 1, 32'h20, 0, 1, 1, 0);
    chk("fullpp_inflight", 32'(hu.inflight), 3);
    chk("fullpp_spec", 32'(hu.spec_ghr), 'h0D);
    cycle(1, 1, 32'h24, 1, 1, 1, 0);
    chk("pp3_inflight", 32'(hu.inflight), 3);
    chk("pp3_spec", 32'(hu.spec_ghr), 'h1B);
    chk("pp3_arch", 32'(hu.arch_ghr), 'h03);

    // Flush with a correct pop: history rewinds to the post-pop commit.
    cycle(1, 1, 32'h40, 1, 1, 0, 1);
    chk("flush_inflight", 32'(hu.inflight), 0);
    chk("flush_arch", 32'(hu.arch_ghr), 'h06);
    chk("flush_spec", 32'(hu.spec_ghr), 'h06);

    // Resolve with an empty FIFO.
    cycle(0, 0, 32'h0, 0, 1, 1, 0);
    chk("uf_err", 32'(hu.err_underflow), 1);
    chk("uf_arch", 32'(hu.arch_ghr), 'h06);
    chk("uf_spec", 32'(hu.spec_ghr), 'h06);

    // Randomized traffic with a mid-run asynchronous reset.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        #2;
        do_reset();
      end
      cycle($urandom_range(0, 3) != 0, 1'($urandom), $urandom, 1'($urandom),
            $urandom_range(0, 2) == 0, 1'($urandom), $urandom_range(0, 31) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
